// File: rtl/fuzz_stim_sequencer_pkg.sv
// Shared types, LCG constants and helper functions for the fuzz stimulus sequencer.
package fuzz_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSTD,
        S_GEN,
        S_APPLY,
        S_SIGCAP,
        S_DONE
    } seq_state_e;

    localparam logic [31:0] LCG_MUL    = 32'h41C64E6D;
    localparam logic [31:0] LCG_INC    = 32'h00003039;
    localparam int          FOLD_MAX_W = 1024;

    function automatic logic [31:0] lcg_step(input logic [31:0] s);
        return s * LCG_MUL + LCG_INC;
    endfunction

    // Caller zero-extends the response bus to FOLD_MAX_W before folding.
    function automatic logic [31:0] fold32(input logic [FOLD_MAX_W-1:0] v);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < FOLD_MAX_W / 32; i++) begin
            f = f ^ v[i*32 +: 32];
        end
        return f;
    endfunction

endpackage

// File: rtl/fuzz_stim_sequencer_if.sv
// Harness-control and DUT-side bus of the fuzz stimulus sequencer.
interface fuzz_stim_sequencer_if #(
    parameter int IN_W  = 138,
    parameter int OUT_W = 159
);
    logic             start;
    logic [31:0]      cycles;
    logic             seed_load;
    logic [31:0]      seed;
    logic [OUT_W-1:0] out_flat;
    logic [IN_W-1:0]  in_flat;
    logic             dut_rst_n;
    logic             step;
    logic             busy;
    logic             done;
    logic [31:0]      vec_cnt;
    logic [31:0]      signature;

    modport master (
        input  start, cycles, seed_load, seed, out_flat,
        output in_flat, dut_rst_n, step, busy, done, vec_cnt, signature
    );

    modport slave (
        output start, cycles, seed_load, seed, out_flat,
        input  in_flat, dut_rst_n, step, busy, done, vec_cnt, signature
    );

endinterface

// File: rtl/fuzz_stim_sequencer_lcg.sv
// 32-bit LCG state register; exposes the next word and the next W-word chain.
module fuzz_lcg32
    import fuzz_seq_pkg::*;
#(
    parameter int          W        = 5,
    parameter logic [31:0] DEF_SEED = 32'd3648514451
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [31:0]     seed,
    input  logic            adv,
    input  logic            adv_vec,
    output logic [31:0]     word,
    output logic [W*32-1:0] vec
);

    logic [31:0] state_q;
    logic [31:0] state_d;
    logic [31:0] acc;

    // Word k of the chain is the state after k+1 steps.
    always_comb begin
        acc = state_q;
        vec = '0;
        for (int k = 0; k < W; k++) begin
            acc = lcg_step(acc);
            vec[k*32 +: 32] = acc;
        end
    end

    assign word = vec[31:0];

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (adv_vec) begin
            state_d = vec[W*32-1 -: 32];
        end else if (adv) begin
            state_d = word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= DEF_SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/fuzz_stim_sequencer.sv
// Fuzz stimulus sequencer: DUT reset phase, LCG vectors, one step per vector.
// Optional response MISR enabled by defining FUZZ_SIG_EN.
module fuzz_stim_sequencer
    import fuzz_seq_pkg::*;
#(
    parameter int          IN_W     = 138,
    parameter int          OUT_W    = 159,
    parameter int          RST_CYC  = 2,
    parameter logic [31:0] DEF_SEED = 32'd3648514451
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fuzz_stim_sequencer_if.master bus
);

    localparam int W    = (IN_W + 31) / 32;
    localparam int VW   = W * 32;
    localparam int WC_W = 6;

    seq_state_e      state_q, state_d;
    logic [31:0]     rcnt_q, rcnt_d;
    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [31:0]     vec_cnt_q, vec_cnt_d;
    logic [VW-1:0]   shadow_q, shadow_d;
    logic [IN_W-1:0] in_flat_q, in_flat_d;
    logic            dut_rst_n_q, dut_rst_n_d;

    logic            lcg_load, lcg_adv, lcg_adv_vec;
    logic [31:0]     lcg_word;
    logic [VW-1:0]   lcg_vec;

`ifdef FUZZ_SIG_EN
    logic [31:0]     sig_q, sig_d;
    logic            sig_samp;
    localparam seq_state_e LAST_NEXT = S_SIGCAP;
`else
    localparam seq_state_e LAST_NEXT = S_DONE;
`endif

    fuzz_lcg32 #(
        .W        (W),
        .DEF_SEED (DEF_SEED)
    ) u_lcg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lcg_load),
        .seed    (bus.seed),
        .adv     (lcg_adv),
        .adv_vec (lcg_adv_vec),
        .word    (lcg_word),
        .vec     (lcg_vec)
    );

    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        wcnt_d      = wcnt_q;
        cnt_d       = cnt_q;
        vec_cnt_d   = vec_cnt_q;
        shadow_d    = shadow_q;
        in_flat_d   = in_flat_q;
        dut_rst_n_d = dut_rst_n_q;
        lcg_load    = 1'b0;
        lcg_adv     = 1'b0;
        lcg_adv_vec = 1'b0;
`ifdef FUZZ_SIG_EN
        sig_d       = sig_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                lcg_load = bus.seed_load;
                if (bus.start) begin
                    cnt_d       = bus.cycles;
                    vec_cnt_d   = '0;
                    rcnt_d      = '0;
                    dut_rst_n_d = 1'b0;
                    state_d     = S_RSTD;
`ifdef FUZZ_SIG_EN
                    sig_d       = '0;
`endif
                end
            end
            S_RSTD: begin
                // Vector 1 is produced in one shot so it is stable before DUT reset releases.
                if (rcnt_q == '0) begin
                    lcg_adv_vec = 1'b1;
                    in_flat_d   = lcg_vec[IN_W-1:0];
                end
                if (rcnt_q == 32'(RST_CYC - 1)) begin
                    dut_rst_n_d = 1'b1;
                    wcnt_d      = '0;
                    state_d     = (cnt_q == '0) ? S_DONE : S_GEN;
                end else begin
                    rcnt_d = rcnt_q + 32'd1;
                end
            end
            S_GEN: begin
                lcg_adv = 1'b1;
                shadow_d[wcnt_q*32 +: 32] = lcg_word;
                if (wcnt_q == WC_W'(W - 1)) begin
                    in_flat_d = shadow_d[IN_W-1:0];
                    vec_cnt_d = vec_cnt_q + 32'd1;
                    wcnt_d    = '0;
                    state_d   = S_APPLY;
                end else begin
                    wcnt_d = wcnt_q + WC_W'(1);
                end
            end
            S_APPLY: begin
                state_d = (vec_cnt_q == cnt_q) ? LAST_NEXT : S_GEN;
            end
            S_SIGCAP: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef FUZZ_SIG_EN
        // The DUT response to a step is visible in the cycle right after APPLY.
        sig_samp = (state_q == S_SIGCAP) ||
                   ((state_q == S_GEN) && (wcnt_q == '0) && (vec_cnt_q != '0));
        if (sig_samp) begin
            sig_d = {sig_q[30:0], sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0]}
                    ^ fold32(FOLD_MAX_W'(bus.out_flat));
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rcnt_q      <= '0;
            wcnt_q      <= '0;
            cnt_q       <= '0;
            vec_cnt_q   <= '0;
            in_flat_q   <= '0;
            dut_rst_n_q <= 1'b0;
`ifdef FUZZ_SIG_EN
            sig_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            wcnt_q      <= wcnt_d;
            cnt_q       <= cnt_d;
            vec_cnt_q   <= vec_cnt_d;
            in_flat_q   <= in_flat_d;
            dut_rst_n_q <= dut_rst_n_d;
`ifdef FUZZ_SIG_EN
            sig_q       <= sig_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign bus.in_flat   = in_flat_q;
    assign bus.dut_rst_n = dut_rst_n_q;
    assign bus.step      = (state_q == S_APPLY);
    assign bus.busy      = (state_q == S_RSTD) || (state_q == S_GEN) ||
                           (state_q == S_APPLY) || (state_q == S_SIGCAP);
    assign bus.done      = (state_q == S_DONE);
    assign bus.vec_cnt   = vec_cnt_q;
`ifdef FUZZ_SIG_EN
    assign bus.signature = sig_q;
`else
    assign bus.signature = '0;
`endif

endmodule

// File: doc/fuzz_stim_sequencer.md
# fuzz_stim_sequencer

Synthesizable stimulus sequencer for the fuzzing harness. It sequences the design under test through a reset phase and then a programmed number of vectors. Each vector is built from a 32-bit LCG and driven onto the DUT's flat input bus, with one DUT clock-enable step per vector. Optionally, the DUT's flat output bus is compacted into a 32-bit signature. The block sits between the harness control registers and the DUT `in_flat`/`out_flat` ports, replacing behavioural testbench stimulus so that runs are cycle-identical across simulators and emulation.

## Interface
- `IN_W`, 138, DUT input bus width (1..1024)
- `OUT_W`, 159, DUT output bus width (1..1024)
- `RST_CYC`, 2, cycles DUT reset is held low at run start (≥1)
- `DEF_SEED`, 32'd3648514451, seed used when `seed_load` is never asserted
- `clk` in 1 — single clock; all logic on rising edge
- `rst_n` in 1 — synchronous, active-low reset
- `start` in 1 — single-cycle run request, honoured only in IDLE or DONE
- `cycles` in 32 — vector count, sampled on accepted `start`
- `seed_load` in 1 — load `seed` into LCG state (IDLE/DONE only)
- `seed` in 32 — seed value
- `out_flat` in OUT_W — DUT response bus
- `in_flat` out IN_W — DUT stimulus bus
- `dut_rst_n` out 1 — DUT reset, active-low
- `step` out 1 — DUT clock enable, one pulse per vector
- `busy` out 1 — high from accepted `start` until DONE
- `done` out 1 — level, high in DONE until next `start`
- `vec_cnt` out 32 — vectors applied this run
- `signature` out 32 — response MISR (`FUZZ_SIG_EN` only)

## Operation
- LCG: `state_next = state*32'h41C64E6D + 32'h3039`, mod 2^32. Each word consumes one LCG step.
- Vector = W = ceil(IN_W/32) words. Word k fills bits [32k+31:32k]; the last word contributes only its low IN_W−32(W−1) bits.
- FSM states: IDLE, RSTD, GEN, APPLY, DONE.
  - IDLE/DONE: accepted `start` latches `cycles` and clears `vec_cnt` and `signature`, then → RSTD.
  - RSTD: `dut_rst_n`=0 for RST_CYC cycles, then → GEN, or → DONE if `cycles`=0.
  - GEN: W cycles, one LCG word per cycle written into the shadow vector, then → APPLY.
  - APPLY: one cycle. `in_flat` ← shadow, `step`=1, `vec_cnt`+1. → DONE if `vec_cnt`+1 = latched count, else → GEN.
- Initial vector: the first W LCG words are generated in RSTD, so `in_flat` is valid before `dut_rst_n` rises. The first GEN after RSTD therefore produces vector 2. Total LCG steps per run = W·(cycles+1).
- LCG state persists across runs unless `seed_load` is asserted, so back-to-back runs continue the sequence.
- `seed_load` with `start` in the same cycle: the seed is loaded first and the run uses the new seed.
- `start` or `seed_load` while busy: ignored.
- `cycles` = 32'hFFFFFFFF is legal; `vec_cnt` does not wrap before DONE.

## Timing
- Reset values: `in_flat`=0, `dut_rst_n`=0, `step`=0, `busy`=0, `done`=0, `vec_cnt`=0, `signature`=0. LCG state = DEF_SEED, FSM = IDLE.
- Reset asserted mid-run aborts immediately to reset values; no partial vector completes.
- `start` at cycle t → `busy`=1 and `dut_rst_n`=0 at t+1.
- `dut_rst_n` rises at t+1+RST_CYC.
- Vector period = W+1 cycles. `step` is asserted in the same cycle `in_flat` updates.
- `done` rises the cycle after the final APPLY. `busy` falls in that same cycle.

## Configuration
- `FUZZ_SIG_EN` defined:
  - `out_flat` is sampled in the first cycle after each `step`, which is the GEN cycle following an APPLY.
  - A one-cycle SIGCAP state is inserted before DONE to capture the response to the last vector.
  - Sampled response is folded to 32 bits by XOR of zero-padded 32-bit slices.
  - Update rule: `signature <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ fold`.
- `FUZZ_SIG_EN` undefined: `signature` is tied to 0 and `out_flat` is unused. There is no SIGCAP state and the done latency above applies.

## Structure
- Package `fuzz_seq_pkg`:
  - FSM state enum
  - LCG multiplier and increment constants
  - `lcg_step` function
  - `fold32` width helper
- Sub-module `fuzz_lcg32` holds the state register, load port and advance enable.
- FSM, shadow vector and MISR stay in `fuzz_stim_sequencer`.

## Test plan
- Seed 0, `cycles`=1, IN_W=138 → `in_flat[31:0]`=32'h00003039 at `dut_rst_n` rise; exactly one `step`; `done`=1 and `vec_cnt`=1.
- Seed 1 → first word 32'h41C67EA6. Bits [137:128] equal bits [9:0] of the 5th LCG word, compared against a bench reference model.
- `cycles`=0 → RSTD then DONE; no `step`; `vec_cnt`=0; `in_flat` holds vector 1.
- `cycles`=100 → 100 `step` pulses spaced W+1=6 cycles apart. `done` arrives 2+600+1 cycles after `start` (one more cycle with `FUZZ_SIG_EN`).
- Reset asserted at vector 40 of 100 → all outputs return to reset values next cycle. A new `start` restarts from DEF_SEED.
- `FUZZ_SIG_EN` with `out_flat` tied to all-ones → `signature` matches the reference MISR after 3 vectors. `start` during a run → no effect.
